// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and the mult/div unit (slave).
// Latency: n/a (wires only).
// Backpressure: none; master must only pulse start while busy is low.
// Optional MULTDIV_UNSIGNED_EN adds the uns (MULTU/DIVU) request bit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             op;
`ifdef MULTDIV_UNSIGNED_EN
  logic             uns;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
`ifdef MULTDIV_UNSIGNED_EN
    output uns,
`endif
    output start, op, a, b,
    input  busy, done, div0, hi, lo
  );

  modport slave (
`ifdef MULTDIV_UNSIGNED_EN
    input  uns,
`endif
    input  start, op, a, b,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 shift-add) / divide (restoring) feeding the Hi/Lo registers.
// Latency: done in the cycle after accept edge + WIDTH+1; divide-by-zero done/div0 the cycle after accept.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy.
// Ports: clk, reset (sync, active-low); bus (slave): start/op/a/b in, busy/done/div0/hi/lo out.
// Optional MULTDIV_UNSIGNED_EN: bus.uns selects MULTU/DIVU (no sign handling).
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             op_q;
  logic             neg_q;     // result (product / quotient) must be negated
  logic             a_neg_q;   // remainder takes the sign of the dividend
  logic             div0_q;
  logic [WIDTH-1:0] opnd;      // MULT: |a| added per step; DIV: |b| subtracted per step
  logic [WIDTH-1:0] acc_hi;    // MULT: upper product; DIV: partial remainder
  logic [WIDTH-1:0] acc_lo;    // MULT: multiplier shifting out; DIV: dividend in, quotient out
  logic [WIDTH-1:0] hi_q, lo_q;

  // Operand magnitudes and signs at accept time
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_by_zero;

  always_comb begin
`ifdef MULTDIV_UNSIGNED_EN
    a_neg = ~bus.uns & bus.a[WIDTH-1];
    b_neg = ~bus.uns & bus.b[WIDTH-1];
`else
    a_neg = bus.a[WIDTH-1];
    b_neg = bus.b[WIDTH-1];
`endif
    mag_a       = a_neg ? -bus.a : bus.a;
    mag_b       = b_neg ? -bus.b : bus.b;
    div_by_zero = (bus.op == OP_DIV) && (bus.b == '0);
  end

  // One iteration step
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Shifted remainder fits in WIDTH+1 bits because remainder < divisor;
    // bit WIDTH of the difference is therefore a clean "borrow" flag.
    div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (op_q == OP_MULT) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      step_hi = div_trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix applied in SIGN
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (op_q == OP_MULT) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else begin
      fix_hi = a_neg_q ? -acc_hi : acc_hi;
      fix_lo = neg_q ? -acc_lo : acc_lo;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = div_by_zero ? DONE : RUN;
      RUN:     if (count == CNT_W'(WIDTH-1)) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
    bus.div0 = (state == DONE) && div0_q;
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

  // Datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      op_q    <= OP_MULT;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            count   <= '0;
            op_q    <= bus.op;
            neg_q   <= a_neg ^ b_neg;
            a_neg_q <= a_neg;
            div0_q  <= div_by_zero;
            acc_hi  <= '0;
            opnd    <= (bus.op == OP_MULT) ? mag_a : mag_b;
            acc_lo  <= (bus.op == OP_MULT) ? mag_b : mag_a;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CNT_W'(1);
        end
        SIGN: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op and runs until done (bounded). edges counts the accept edge as 1.
  // A stray start (MULT 3x3) is pulsed during RUN when inject_at matches.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input int inject_at,
                       output int edges, output bit busy_ok, output bit div0_seen);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    tick();
    edges = 1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    busy_ok = 1'b1;
    div0_seen = 1'b0;
    while (!bus.done && edges < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.div0) div0_seen = 1'b1;
      if (edges == inject_at) begin
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      edges++;
    end
    bus.start = 1'b0;
    if (bus.div0) div0_seen = 1'b1;
  endtask

  int edges;
  bit busy_ok;
  bit div0_seen;
  int done_cnt;

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
`ifdef MULTDIV_UNSIGNED_EN
    bus.uns = 1'b0;
`endif
    tick(); tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_div0", {31'd0, bus.div0}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;
    tick();

    // MULT 7 x -3 = -21
    do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, -1, edges, busy_ok, div0_seen);
    chk("m1_latency", edges, 32'd34);
    chk("m1_busy", {31'd0, busy_ok}, 32'd1);
    chk("m1_hi", bus.hi, 32'hFFFF_FFFF);
    chk("m1_lo", bus.lo, 32'hFFFF_FFEB);
    chk("m1_div0", {31'd0, div0_seen}, 32'd0);
    tick();
    chk("m1_done_once", {31'd0, bus.done}, 32'd0);
    chk("m1_idle", {31'd0, bus.busy}, 32'd0);

    // MULT 0x80000000 x 0x80000000 = 2^62
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, edges, busy_ok, div0_seen);
    chk("m2_hi", bus.hi, 32'h4000_0000);
    chk("m2_lo", bus.lo, 32'h0000_0000);
    chk("m2_div0", {31'd0, div0_seen}, 32'd0);
    tick();

    // DIV -7 / 2 -> q -3, r -1
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, edges, busy_ok, div0_seen);
    chk("d1_latency", edges, 32'd34);
    chk("d1_lo", bus.lo, 32'hFFFF_FFFD);
    chk("d1_hi", bus.hi, 32'hFFFF_FFFF);
    tick();

    // Preload hi/lo = 0x11/0x22 via 0x2211 / 0x100
    do_op(OP_DIV, 32'h0000_2211, 32'h0000_0100, -1, edges, busy_ok, div0_seen);
    chk("pre_hi", bus.hi, 32'h11);
    chk("pre_lo", bus.lo, 32'h22);
    tick();

    // DIV 5 / 0
    do_op(OP_DIV, 32'd5, 32'd0, -1, edges, busy_ok, div0_seen);
    chk("z_latency", edges, 32'd1);
    chk("z_done", {31'd0, bus.done}, 32'd1);
    chk("z_div0", {31'd0, bus.div0}, 32'd1);
    chk("z_hi", bus.hi, 32'h11);
    chk("z_lo", bus.lo, 32'h22);
    tick();
    chk("z_busy_fall", {31'd0, bus.busy}, 32'd0);
    chk("z_div0_fall", {31'd0, bus.div0}, 32'd0);

    // DIV 0x80000000 / -1 wraps, stray start during RUN
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5, edges, busy_ok, div0_seen);
    chk("w_latency", edges, 32'd34);
    chk("w_lo", bus.lo, 32'h8000_0000);
    chk("w_hi", bus.hi, 32'h0000_0000);
    chk("w_div0", {31'd0, div0_seen}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    chk("w_single_done", done_cnt, 32'd0);
    chk("w_lo_kept", bus.lo, 32'h8000_0000);

    // Reset mid-MULT at iteration 10
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd1000; bus.b = 32'd1000;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    chk("r_busy", {31'd0, bus.busy}, 32'd0);
    chk("r_done", {31'd0, bus.done}, 32'd0);
    chk("r_hi", bus.hi, 32'd0);
    chk("r_lo", bus.lo, 32'd0);
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    chk("r_no_done", done_cnt, 32'd0);

    // Fresh MULT 3 x 4
    do_op(OP_MULT, 32'd3, 32'd4, -1, edges, busy_ok, div0_seen);
    chk("f_latency", edges, 32'd34);
    chk("f_lo", bus.lo, 32'd12);
    chk("f_hi", bus.hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
